machine_ctl_ws: RTL and testbench
=================================

Name: machine_ctl_ws

Overview:
- Parametrised successor to the CPU's six-phase instruction-cycle controller.
- Sequences fetch, decode, operand fetch, execute and writeback for the accumulator datapath.
- Adds memory wait states through a mem_ready handshake, a bus-timeout error, a sticky HALTED state with resume, and a configurable opcode width and encoding.
- Sits between the instruction register/ALU and the PC, accumulator, ROM/RAM and data-bus driver.

Parameters:
- OPW, 4, opcode width in bits (4..8).
- OP_HLT, 0, halt opcode.
- OP_SKZ, 1, skip-if-zero opcode.
- OP_STO, 9, store-accumulator opcode.
- OP_JMP, 13, jump opcode.
- WAIT_MAX, 8, maximum consecutive not-ready cycles per access before a bus error (1..255).

Ports:
- clk  in  1  system clock; all state updates on negedge clk.
- ena  in  1  synchronous active-low reset (0 = reset, sampled on negedge clk).
- opcode  in  OPW  current instruction opcode from the IR.
- zero  in  1  accumulator-is-zero flag.
- mem_ready  in  1  memory access complete; sampled while rd or wr is high.
- resume  in  1  leave HALTED; level, sampled on negedge.
- inc_pc  out  1  increment PC.
- load_acc  out  1  load accumulator.
- load_pc  out  1  load PC from operand.
- rd  out  1  memory read.
- wr  out  1  memory write.
- load_ir  out  1  load instruction register.
- datactl_ena  out  1  drive accumulator onto data bus.
- halt  out  1  machine halted.
- bus_err  out  1  wait timeout occurred; sticky until resume or reset.
- instr_cnt  out  16  retired-instruction count (present only with the optional feature).

Behaviour:
- All outputs are registered.
- On a negedge in state S, outputs take V(S) and state moves to next(S).
- Opcode classes:
  - HLT: opcode==OP_HLT.
  - SKZ: opcode==OP_SKZ.
  - STO: opcode==OP_STO.
  - JMP: opcode==OP_JMP.
  - ALU: every other value.
- Reset (ena=0 at negedge):
  - state=S0; all outputs 0, bus_err 0, wait_cnt 0, instr_cnt 0.
  - Takes priority over everything, including mid-wait and HALTED.
- States and V(S), 3-bit encoding:
  - S0 FETCH: inc_pc=1, rd=1, load_ir=1; ->S1.
  - S1 IDLE: all 0; ->S2.
  - S2 DECODE: all 0; ->HALTED if HLT, else ->S3.
  - S3 OPFETCH: JMP load_pc=1; ALU rd=1; STO datactl_ena=1; else 0; ->S4.
  - S4 EXEC: ALU load_acc=1, rd=1; SKZ with zero=1 inc_pc=1; JMP inc_pc=1, load_pc=1; STO wr=1, datactl_ena=1; else 0; ->S5.
  - S5 WB: STO datactl_ena=1; ALU rd=1; else 0; ->S0. instr_cnt increments on this transition.
  - S6 HALTED: halt=1, other controls 0. On resume=1: state=S0, outputs 0, bus_err cleared.
  - S7: unused; behaves as reset (outputs 0, ->S0).
- Wait states, checked at each negedge before normal sequencing:
  - If registered rd|wr=1 and mem_ready=0, state and all outputs hold and wait_cnt increments.
  - If wait_cnt==WAIT_MAX-1 at that edge: all controls 0, bus_err=1, halt=1, state=HALTED.
  - mem_ready=1, or rd=wr=0, clears wait_cnt and sequencing proceeds.
- Opcode, zero and resume are sampled only at the edge that uses them; changes during a wait have no effect until that edge.
- mem_ready is ignored in all states whose registered rd=wr=0.
- resume=1 outside HALTED is ignored.

Optional Feature:
- Macro: MACHINE_CTL_PERF_EN.
- Defined: instr_cnt[15:0] is present. It increments on every S5->S0 transition, wraps from 0xFFFF to 0, holds during waits and in HALTED, and clears on reset only.
- Undefined: the port and counter do not exist; all other behaviour is identical.

Test Plan:
- ena=0 for 2 edges, then 1 with opcode=2 (ADD), mem_ready=1 -> per-negedge control vector {inc_pc,load_acc,load_pc,rd,wr,load_ir,datactl_ena,halt}: 10010100, 00000000, 00000000, 00010000, 01010000, 00010000, then repeats; instr_cnt=1 after the first S5.
- opcode=9 (STO), mem_ready=0 for 3 edges while wr=1 -> wr=1, datactl_ena=1 held 3 extra cycles; sequence then completes normally; bus_err stays 0.
- WAIT_MAX=4, opcode=2, mem_ready held 0 at FETCH -> after 4 held edges, halt=1, bus_err=1, all other controls 0; resume=1 -> S0, bus_err=0.
- opcode=0 (HLT) -> halt=1 from S2 onward and stays for 20 cycles; resume pulse -> FETCH vector 10010100 one edge later.
- opcode=1 with zero=1 -> inc_pc=1 in EXEC; with zero=0 -> EXEC vector all 0. opcode=13 (JMP) -> load_pc=1 in S3, inc_pc=1 and load_pc=1 in S4.
- ena=0 asserted mid-wait in S4 of STO -> next edge all outputs 0 and state S0; instr_cnt=0.

Source files
------------

// File: rtl/machine_ctl_ws.sv
`default_nettype none
// ============================================================================
//  Module      : machine_ctl_ws
//  Description : Instruction-cycle controller for the accumulator CPU.
//                Sequences FETCH, IDLE, DECODE, OPFETCH, EXEC and WB, with
//                memory wait states (mem_ready), a bus-timeout error and a
//                sticky HALTED state that is left through resume.
//                All state and outputs update on the falling edge of clk.
//  Ports       : clk          system clock (negedge active)
//                ena          synchronous active-low reset
//                opcode       current opcode from the IR (OPW bits)
//                zero         accumulator-is-zero flag
//                mem_ready    memory access complete (used while rd|wr)
//                resume       leave HALTED (level)
//                inc_pc, load_acc, load_pc, rd, wr, load_ir, datactl_ena,
//                halt         registered control outputs
//                bus_err      sticky wait-timeout flag
//                instr_cnt    retired-instruction count (MACHINE_CTL_PERF_EN)
//  Options     : define MACHINE_CTL_PERF_EN to add the instr_cnt counter.
//  Revision    : 1.0  initial release
// ============================================================================
module machine_ctl_ws #(
    parameter int unsigned OPW      = 4,
    parameter int unsigned OP_HLT   = 0,
    parameter int unsigned OP_SKZ   = 1,
    parameter int unsigned OP_STO   = 9,
    parameter int unsigned OP_JMP   = 13,
    parameter int unsigned WAIT_MAX = 8
) (
    input  logic           clk,
    input  logic           ena,
    input  logic [OPW-1:0] opcode,
    input  logic           zero,
    input  logic           mem_ready,
    input  logic           resume,
    output logic           inc_pc,
    output logic           load_acc,
    output logic           load_pc,
    output logic           rd,
    output logic           wr,
    output logic           load_ir,
    output logic           datactl_ena,
    output logic           halt,
    output logic           bus_err
`ifdef MACHINE_CTL_PERF_EN
    ,
    output logic [15:0]    instr_cnt
`endif
);

    typedef enum logic [2:0] {
        S_FETCH   = 3'd0,
        S_IDLE    = 3'd1,
        S_DECODE  = 3'd2,
        S_OPFETCH = 3'd3,
        S_EXEC    = 3'd4,
        S_WB      = 3'd5,
        S_HALTED  = 3'd6,
        S_UNUSED  = 3'd7
    } state_t;

    // Control vector bit order: {inc_pc,load_acc,load_pc,rd,wr,load_ir,datactl_ena,halt}
    localparam logic [7:0] C_NONE   = 8'b0000_0000;
    localparam logic [7:0] C_FETCH  = 8'b1001_0100;
    localparam logic [7:0] C_HALT   = 8'b0000_0001;
    localparam logic [7:0] C_RD     = 8'b0001_0000;
    localparam logic [7:0] C_DATA   = 8'b0000_0010;
    localparam logic [7:0] C_LDPC   = 8'b0010_0000;
    localparam logic [7:0] C_ALUEX  = 8'b0101_0000;
    localparam logic [7:0] C_INCPC  = 8'b1000_0000;
    localparam logic [7:0] C_JMPEX  = 8'b1010_0000;
    localparam logic [7:0] C_STOEX  = 8'b0000_1010;

    localparam logic [7:0] WAIT_LAST = 8'(WAIT_MAX - 1);

    state_t     state_q;
    logic [7:0] ctl_q;
    logic       bus_err_q;
    logic [7:0] wait_cnt_q;
`ifdef MACHINE_CTL_PERF_EN
    logic [15:0] instr_cnt_q;
`endif

    // Opcode classes; anything not explicitly decoded is an ALU operation.
    logic w_is_hlt, w_is_skz, w_is_sto, w_is_jmp, w_is_alu;
    assign w_is_hlt = (opcode == OPW'(OP_HLT));
    assign w_is_skz = (opcode == OPW'(OP_SKZ));
    assign w_is_sto = (opcode == OPW'(OP_STO));
    assign w_is_jmp = (opcode == OPW'(OP_JMP));
    assign w_is_alu = !(w_is_hlt || w_is_skz || w_is_sto || w_is_jmp);

    // Outputs issued on the edge taken in the given state.
    function automatic logic [7:0] ctl_vec(input state_t s);
        logic [7:0] v;
        v = C_NONE;
        case (s)
            S_FETCH:   v = C_FETCH;
            S_OPFETCH: begin
                if (w_is_jmp)      v = C_LDPC;
                else if (w_is_alu) v = C_RD;
                else if (w_is_sto) v = C_DATA;
            end
            S_EXEC: begin
                if (w_is_alu)              v = C_ALUEX;
                else if (w_is_skz && zero) v = C_INCPC;
                else if (w_is_jmp)         v = C_JMPEX;
                else if (w_is_sto)         v = C_STOEX;
            end
            S_WB: begin
                if (w_is_sto)      v = C_DATA;
                else if (w_is_alu) v = C_RD;
            end
            default:   v = C_NONE;
        endcase
        return v;
    endfunction

    // A pending access is one whose registered strobe is still asserted.
    logic w_waiting;
    assign w_waiting = (ctl_q[4] || ctl_q[3]) && !mem_ready;

    always_ff @(negedge clk) begin
        if (!ena) begin
            state_q    <= S_FETCH;
            ctl_q      <= C_NONE;
            bus_err_q  <= 1'b0;
            wait_cnt_q <= 8'd0;
`ifdef MACHINE_CTL_PERF_EN
            instr_cnt_q <= 16'd0;
`endif
        end else if (w_waiting) begin
            if (wait_cnt_q == WAIT_LAST) begin
                // Timeout: abandon the access and park in HALTED.
                state_q    <= S_HALTED;
                ctl_q      <= C_HALT;
                bus_err_q  <= 1'b1;
                wait_cnt_q <= 8'd0;
            end else begin
                wait_cnt_q <= wait_cnt_q + 8'd1;
            end
        end else begin
            wait_cnt_q <= 8'd0;
            case (state_q)
                S_FETCH: begin
                    ctl_q   <= ctl_vec(state_q);
                    state_q <= S_IDLE;
                end
                S_IDLE: begin
                    ctl_q   <= ctl_vec(state_q);
                    state_q <= S_DECODE;
                end
                S_DECODE: begin
                    ctl_q   <= ctl_vec(state_q);
                    state_q <= w_is_hlt ? S_HALTED : S_OPFETCH;
                end
                S_OPFETCH: begin
                    ctl_q   <= ctl_vec(state_q);
                    state_q <= S_EXEC;
                end
                S_EXEC: begin
                    ctl_q   <= ctl_vec(state_q);
                    state_q <= S_WB;
                end
                S_WB: begin
                    ctl_q   <= ctl_vec(state_q);
                    state_q <= S_FETCH;
`ifdef MACHINE_CTL_PERF_EN
                    instr_cnt_q <= instr_cnt_q + 16'd1;
`endif
                end
                S_HALTED: begin
                    if (resume) begin
                        state_q   <= S_FETCH;
                        ctl_q     <= C_NONE;
                        bus_err_q <= 1'b0;
                    end else begin
                        ctl_q <= C_HALT;
                    end
                end
                default: begin
                    state_q <= S_FETCH;
                    ctl_q   <= C_NONE;
                end
            endcase
        end
    end

    assign inc_pc      = ctl_q[7];
    assign load_acc    = ctl_q[6];
    assign load_pc     = ctl_q[5];
    assign rd          = ctl_q[4];
    assign wr          = ctl_q[3];
    assign load_ir     = ctl_q[2];
    assign datactl_ena = ctl_q[1];
    assign halt        = ctl_q[0];
    assign bus_err     = bus_err_q;
`ifdef MACHINE_CTL_PERF_EN
    assign instr_cnt   = instr_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_machine_ctl_ws.sv
`default_nettype none
// ============================================================================
//  Module      : tb_machine_ctl_ws
//  Description : Self-checking bench for machine_ctl_ws (WAIT_MAX=4).
//                Stimulus pushes hand-computed control vectors into a
//                scoreboard queue; a monitor pops one entry per cycle and
//                compares it with the DUT outputs between falling edges.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_machine_ctl_ws;

    localparam logic [7:0] Z   = 8'b0000_0000;
    localparam logic [7:0] F   = 8'b1001_0100;
    localparam logic [7:0] H   = 8'b0000_0001;
    localparam logic [7:0] R   = 8'b0001_0000;
    localparam logic [7:0] EXA = 8'b0101_0000;
    localparam logic [7:0] ST3 = 8'b0000_0010;
    localparam logic [7:0] ST4 = 8'b0000_1010;
    localparam logic [7:0] ST5 = 8'b0000_0010;
    localparam logic [7:0] SKE = 8'b1000_0000;
    localparam logic [7:0] JM3 = 8'b0010_0000;
    localparam logic [7:0] JM4 = 8'b1010_0000;

    logic       clk;
    logic       ena;
    logic [3:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       resume;
    logic       inc_pc, load_acc, load_pc, rd, wr, load_ir, datactl_ena, halt, bus_err;
`ifdef MACHINE_CTL_PERF_EN
    logic [15:0] instr_cnt;
`endif

    machine_ctl_ws #(.OPW(4), .WAIT_MAX(4)) dut (
        .clk         (clk),
        .ena         (ena),
        .opcode      (opcode),
        .zero        (zero),
        .mem_ready   (mem_ready),
        .resume      (resume),
        .inc_pc      (inc_pc),
        .load_acc    (load_acc),
        .load_pc     (load_pc),
        .rd          (rd),
        .wr          (wr),
        .load_ir     (load_ir),
        .datactl_ena (datactl_ena),
        .halt        (halt),
        .bus_err     (bus_err)
`ifdef MACHINE_CTL_PERF_EN
        ,
        .instr_cnt   (instr_cnt)
`endif
    );

    initial clk = 1'b1;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]  vec;
        logic        err;
        logic [15:0] cnt;
        logic [7:0]  id;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        m_e;
    int          n_vec = 0;
    int          n_bad = 0;
    int          n_id  = 0;
    logic [15:0] m_cnt = 16'd0;

    // Drive inputs for the next falling edge and record the expected result.
    task automatic step(input logic e, input logic [3:0] op, input logic z,
                        input logic mr, input logic rs, input logic [7:0] v,
                        input logic er, input logic retire);
        exp_t x;
        @(posedge clk);
        #1;
        ena = e; opcode = op; zero = z; mem_ready = mr; resume = rs;
        if (!e)          m_cnt = 16'd0;
        else if (retire) m_cnt = m_cnt + 16'd1;
        x.vec = v; x.err = er; x.cnt = m_cnt; x.id = n_id[7:0];
        sb_q.push_back(x);
        n_id++;
    endtask

    // Monitor: outputs change on negedge, so they are stable here.
    always @(posedge clk) begin
        if (sb_q.size() > 0) begin
            m_e = sb_q.pop_front();
            n_vec++;
            if ({inc_pc, load_acc, load_pc, rd, wr, load_ir, datactl_ena, halt} !== m_e.vec ||
                bus_err !== m_e.err) begin
                n_bad++;
                $display("FAIL ctl#%0d: got ctl=%b bus_err=%b, expected ctl=%b bus_err=%b",
                         m_e.id,
                         {inc_pc, load_acc, load_pc, rd, wr, load_ir, datactl_ena, halt},
                         bus_err, m_e.vec, m_e.err);
            end
`ifdef MACHINE_CTL_PERF_EN
            n_vec++;
            if (instr_cnt !== m_e.cnt) begin
                n_bad++;
                $display("FAIL cnt#%0d: got instr_cnt=%0d, expected %0d",
                         m_e.id, instr_cnt, m_e.cnt);
            end
`endif
        end
    end

    initial begin
        ena = 1'b0; opcode = 4'd0; zero = 1'b0; mem_ready = 1'b1; resume = 1'b0;

        // Reset for two edges.
        step(0, 2, 0, 1, 0, Z, 0, 0);
        step(0, 2, 0, 1, 0, Z, 0, 0);

        // Two full ALU (ADD) instructions.
        for (int r = 0; r < 2; r++) begin
            step(1, 2, 0, 1, 0, F,   0, 0);
            step(1, 2, 0, 1, 0, Z,   0, 0);
            step(1, 2, 0, 1, 0, Z,   0, 0);
            step(1, 2, 0, 1, 0, R,   0, 0);
            step(1, 2, 0, 1, 0, EXA, 0, 0);
            step(1, 2, 0, 1, 0, R,   0, 1);
        end

        // STO with three wait cycles on the write (one short of timeout).
        step(1, 9, 0, 1, 0, F,   0, 0);
        step(1, 9, 0, 1, 0, Z,   0, 0);
        step(1, 9, 0, 1, 0, Z,   0, 0);
        step(1, 9, 0, 1, 0, ST3, 0, 0);
        step(1, 9, 0, 1, 0, ST4, 0, 0);
        for (int w = 0; w < 3; w++) step(1, 9, 0, 0, 0, ST4, 0, 0);
        step(1, 9, 0, 1, 0, ST5, 0, 1);

        // Fetch never acknowledged: fourth not-ready edge raises bus_err.
        step(1, 2, 0, 1, 0, F, 0, 0);
        for (int w = 0; w < 3; w++) step(1, 2, 0, 0, 0, F, 0, 0);
        step(1, 2, 0, 0, 0, H, 1, 0);
        step(1, 2, 0, 0, 0, H, 1, 0);
        step(1, 2, 0, 0, 0, H, 1, 0);
        step(1, 2, 0, 0, 1, Z, 0, 0);
        step(1, 2, 0, 1, 0, F,   0, 0);
        step(1, 2, 0, 1, 0, Z,   0, 0);
        step(1, 2, 0, 1, 0, Z,   0, 0);
        step(1, 2, 0, 1, 0, R,   0, 0);
        step(1, 2, 0, 1, 0, EXA, 0, 0);
        step(1, 2, 0, 1, 0, R,   0, 1);

        // HLT: parks in HALTED for 20 cycles, resume restarts at FETCH.
        step(1, 0, 0, 1, 0, F, 0, 0);
        step(1, 0, 0, 1, 0, Z, 0, 0);
        step(1, 0, 0, 1, 0, Z, 0, 0);
        for (int k = 0; k < 20; k++) step(1, 0, 0, 1, 0, H, 0, 0);
        step(1, 0, 0, 1, 1, Z, 0, 0);
        step(1, 1, 1, 1, 0, F, 0, 0);

        // SKZ with zero=1 (resume held high, must be ignored).
        step(1, 1, 1, 1, 1, Z,   0, 0);
        step(1, 1, 1, 1, 1, Z,   0, 0);
        step(1, 1, 1, 1, 1, Z,   0, 0);
        step(1, 1, 1, 1, 1, SKE, 0, 0);
        step(1, 1, 1, 1, 1, Z,   0, 1);

        // SKZ with zero=0.
        step(1, 1, 0, 1, 0, F, 0, 0);
        step(1, 1, 0, 1, 0, Z, 0, 0);
        step(1, 1, 0, 1, 0, Z, 0, 0);
        step(1, 1, 0, 1, 0, Z, 0, 0);
        step(1, 1, 0, 1, 0, Z, 0, 0);
        step(1, 1, 0, 1, 0, Z, 0, 1);

        // JMP.
        step(1, 13, 0, 1, 0, F,   0, 0);
        step(1, 13, 0, 1, 0, Z,   0, 0);
        step(1, 13, 0, 1, 0, Z,   0, 0);
        step(1, 13, 0, 1, 0, JM3, 0, 0);
        step(1, 13, 0, 1, 0, JM4, 0, 0);
        step(1, 13, 0, 1, 0, Z,   0, 1);

        // Reset while STO is waiting in EXEC.
        step(1, 9, 0, 1, 0, F,   0, 0);
        step(1, 9, 0, 1, 0, Z,   0, 0);
        step(1, 9, 0, 1, 0, Z,   0, 0);
        step(1, 9, 0, 1, 0, ST3, 0, 0);
        step(1, 9, 0, 1, 0, ST4, 0, 0);
        step(1, 9, 0, 0, 0, ST4, 0, 0);
        step(0, 9, 0, 0, 0, Z,   0, 0);
        step(1, 2, 0, 1, 0, F,   0, 0);
        step(1, 2, 0, 1, 0, Z,   0, 0);

        @(posedge clk);
        #1;
        if (sb_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending entries, expected 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
